// File: rtl/echo_sample_buffer_pkg.sv
// Shared definitions for the echo acquisition path: word format and buffer depth.
// The control unit's buffer input is typed with echo_word_t so both sides stay in step.
package pack;

    localparam int ECHO_W     = 25;
    localparam int ECHO_DEPTH = 16;

    typedef logic [ECHO_W-1:0] echo_word_t;

endpackage : pack

// File: rtl/echo_sample_buffer_ram.sv
// Simple dual-port storage array for the echo buffer: synchronous write,
// combinational read, no reset on the contents.
module echo_buf_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 25,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Array write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule : echo_buf_ram

// File: rtl/echo_sample_buffer.sv
// Elastic FIFO between echo acquisition and the control unit, with registered
// read data, occupancy/status decodes and a sticky overflow flag.
module echo_sample_buffer
    import pack::*;
#(
    parameter int DEPTH    = ECHO_DEPTH,
    parameter int WIDTH    = ECHO_W,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     send_en,
    output logic [WIDTH-1:0]         buf_data,
    output logic                     buf_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wp_r;
    logic [AW-1:0]    rp_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic [WIDTH-1:0] rd_data_s;
    logic             push_s;
    logic             pop_s;
    logic             drop_s;

    assign empty       = (count_r == {CW{1'b0}});
    assign full        = (count_r == CW'(DEPTH));
    assign almost_full = (count_r >= CW'(AF_LEVEL));
    assign count       = count_r;

    // A pop at full frees the slot, so a simultaneous write is accepted; flush blocks both.
    assign pop_s  = send_en && !empty && !flush;
    assign push_s = wr_en && (!full || pop_s) && !flush;
    assign drop_s = wr_en && !push_s && !flush;

    echo_buf_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (push_s),
        .wr_addr (wp_r),
        .wr_data (wr_data),
        .rd_addr (rp_r),
        .rd_data (rd_data_s)
    );

    // Occupancy update from the push/pop pair.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy, overflow and the registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_r      <= {AW{1'b0}};
            rp_r      <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            buf_data  <= {WIDTH{1'b0}};
            buf_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (flush) begin
            wp_r      <= {AW{1'b0}};
            rp_r      <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            buf_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push_s) begin
                wp_r <= wp_r + AW'(1);
            end
            if (pop_s) begin
                rp_r     <= rp_r + AW'(1);
                buf_data <= rd_data_s;
            end
            if (drop_s) begin
                overflow <= 1'b1;
            end
            buf_valid <= pop_s;
            count_r   <= count_next_s;
        end
    end

endmodule : echo_sample_buffer

// File: tb/tb_echo_sample_buffer.sv
// Self-checking bench: queue-based reference model compared every cycle, plus
// literal expectations for the directed scenarios.
module tb_echo_sample_buffer;

    localparam int DEPTH = 16;
    localparam int WIDTH = 25;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             send_en = 1'b0;
    logic [WIDTH-1:0] buf_data;
    logic             buf_valid;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic             overflow;
    logic [4:0]       count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_data  = '0;
    logic             m_valid = 1'b0;
    logic             m_ovf   = 1'b0;

    echo_sample_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .send_en     (send_en),
        .buf_data    (buf_data),
        .buf_valid   (buf_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= DEPTH - 2));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("buf_valid", 32'(buf_valid), 32'(m_valid));
        chk("buf_data", 32'(buf_data), 32'(m_data));
    endtask

    // One clock: apply inputs, advance the model by the FIFO rules, compare after the edge.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic s, input logic f);
        bit do_pop;
        bit do_push;
        wr_en   = w;
        wr_data = d;
        send_en = s;
        flush   = f;
        @(posedge clk);
        if (f) begin
            q.delete();
            m_ovf   = 1'b0;
            m_valid = 1'b0;
        end else begin
            do_pop  = s && (q.size() > 0);
            do_push = w && ((q.size() < DEPTH) || do_pop);
            m_valid = do_pop;
            if (do_pop) m_data = q.pop_front();
            if (do_push) q.push_back(d);
            if (w && !do_push) m_ovf = 1'b1;
        end
        #1;
        check_model();
    endtask

    initial begin
        logic [WIDTH-1:0] last;

        // Reset state
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(buf_valid), 32'd0);
        chk("rst_data", 32'(buf_data), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

        // Fill then drain in order
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, WIDTH'(i), 1'b0, 1'b0);
            chk("af_lit", 32'(almost_full), 32'(i >= 14));
        end
        chk("full_lit", 32'(full), 32'd1);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_valid", 32'(buf_valid), 32'd1);
            chk("drain_data", 32'(buf_data), 32'(i));
        end
        step(1'b0, '0, 1'b0, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Overflow at full, dropped word never emerges, flush clears
        for (int i = 1; i <= 16; i++) step(1'b1, WIDTH'(100 + i), 1'b0, 1'b0);
        step(1'b1, 25'h1ABCDEF, 1'b0, 1'b0);
        chk("ovf_lit", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("ovf_no_drop", 32'(buf_data == 25'h1ABCDEF), 32'd0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        chk("flush_ovf", 32'(overflow), 32'd0);
        chk("flush_count", 32'(count), 32'd0);

        // Simultaneous push/pop at full
        for (int i = 1; i <= 16; i++) step(1'b1, WIDTH'(200 + i), 1'b0, 1'b0);
        step(1'b1, 25'h0AAAAAA, 1'b1, 1'b0);
        chk("sim_count", 32'(count), 32'd16);
        chk("sim_ovf", 32'(overflow), 32'd0);
        chk("sim_oldest", 32'(buf_data), 32'd201);
        last = '0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            if (buf_valid) last = buf_data;
        end
        chk("sim_last", 32'(last), 32'h0AAAAAA);

        // Write while empty with send_en high: no fall-through
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 25'h1555555, 1'b1, 1'b0);
        chk("ew_valid", 32'(buf_valid), 32'd0);
        chk("ew_count", 32'(count), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("ew_valid2", 32'(buf_valid), 32'd1);
        chk("ew_data", 32'(buf_data), 32'h1555555);

        // Random traffic across pointer wrap
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        end

        // Asynchronous reset with a pop in flight at count 7
        step(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, WIDTH'($urandom), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("mid_count7", 32'(count), 32'd7);
        chk("mid_valid1", 32'(buf_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_valid", 32'(buf_valid), 32'd0);
        chk("arst_data", 32'(buf_data), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        q.delete();
        m_data  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        send_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_echo_sample_buffer
